ps2_device: RTL
===============

PS2_DEVICE -- requirements
Module: ps2_device

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4: length of each PS/2 clock half-period in clk cycles; legal values 2..255.
REQ-002 The block SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port n_rst  input  1  reset, asynchronous, active-low.
REQ-004 The block SHALL have port clk_in  input  1  sensed PS/2 clock line level.
REQ-005 The block SHALL have port data_in  input  1  sensed PS/2 data line level.
REQ-006 The block SHALL have port n_clk_out  output  1  1 pulls the PS/2 clock line low, 0 releases it.
REQ-007 The block SHALL have port n_data_out  output  1  1 pulls the PS/2 data line low, 0 releases it.
REQ-008 The block SHALL have port tx_data  input  8  byte to send to the host.
REQ-009 The block SHALL have ports tx_valid (input, 1) and tx_ready (output, 1) forming a valid/ready handshake for tx_data.
REQ-010 The block SHALL have port rx_data  output  8  last byte received from the host.
REQ-011 The block SHALL have ports rx_valid and rx_err (output, 1 each), each a one-cycle pulse.
REQ-012 The block SHALL have port busy  output  1  high while any frame is in progress.

Function
REQ-013 clk_in and data_in SHALL pass through two-flop synchronisers; all decisions use the synchronised values (2-cycle latency).
REQ-014 FSM states SHALL be IDLE, TX, RX, ACK; busy = (state != IDLE).
REQ-015 Generated PS/2 clock: each bit SHALL be one high half-period followed by one low half-period, each CLK_DIV cycles (n_clk_out=0, then 1).
REQ-016 Transfer: tx_valid & tx_ready at an edge accepts tx_data; tx_ready SHALL drop in the next cycle and stay low until the frame ends.
REQ-017 TX frame SHALL be 11 bits: start 0, tx_data[0..7] LSB first, odd parity, stop 1; n_data_out = ~bit.
REQ-018 Each TX bit SHALL be driven from the first cycle of its high half-period; the first bit starts in the cycle after acceptance.
REQ-019 TX frame length SHALL be 22*CLK_DIV cycles; then n_data_out=0, state IDLE, tx_ready=1.
REQ-020 Inhibit: if synchronised clk_in is low during a TX high half-period before the stop bit, the frame SHALL abort, both lines released, and the byte retained and retransmitted from the start bit once clk_in has been high for 2*CLK_DIV consecutive cycles.
REQ-021 Inhibit during the stop bit SHALL be ignored; the frame completes.
REQ-022 Request-to-send: in IDLE, synchronised clk_in=1 and data_in=0 for 2 consecutive cycles SHALL enter RX.
REQ-023 If RTS and an accepted or pending TX coincide in IDLE, RTS SHALL win; the TX byte stays pending and is sent after the RX frame.
REQ-024 RX SHALL generate 10 clock pulses and sample data_in at the last cycle of each high half-period: 8 data bits LSB first, parity, stop.
REQ-025 If stop = 1, ACK SHALL follow: one more clock pulse with n_data_out=1 for the full pulse, then release and return to IDLE.
REQ-026 If stop = 0, no ACK pulse SHALL be generated; rx_err pulses and the FSM returns to IDLE.
REQ-027 On completion rx_data SHALL update to the 8 data bits; rx_valid pulses if parity is odd and stop = 1, otherwise rx_err pulses; never both.
REQ-028 rx_valid/rx_err SHALL pulse in the cycle IDLE is re-entered.

Reset
REQ-029 While n_rst=0: n_clk_out=0, n_data_out=0, tx_ready=1, rx_valid=0, rx_err=0, rx_data=0, busy=0, state IDLE, no pending byte.
REQ-030 Reset asserted mid-frame SHALL release both lines immediately and discard the frame and any pending byte.

Verification
REQ-031 CLK_DIV=4, send 0x1C -> 11-bit frame 0,0,0,1,1,1,0,0,0,0,1 (parity 0), 88 cycles, tx_ready high again.
REQ-032 Host RTS then sends 0xED, parity 1, stop 1 -> ACK pulse with data low, rx_data=0xED, one rx_valid pulse.
REQ-033 Host sends 0xED with parity 0 -> rx_data=0xED, rx_err pulse, no rx_valid, ACK still given.
REQ-034 Host holds clk_in low during data bit 3 of 0x55 -> lines released, busy=0, full frame of 0x55 resent after 2*CLK_DIV cycles of high clk_in.
REQ-035 tx_valid and RTS in the same cycle -> RX frame first, then the TX frame; no byte lost.
REQ-036 n_rst pulsed low mid-TX -> both lines released in the same cycle, tx_ready=1, no retransmission.

Source files
------------

// File: rtl/ps2_device.sv
// PS/2 device-side link: sends host-bound bytes, receives host commands with ACK, and generates the PS/2 clock.
// Latency: line inputs go through a 2-flop synchroniser; a TX frame takes 22*CLK_DIV cycles after acceptance.
// Backpressure: tx_ready stays low while a byte is held (in flight, inhibited, or deferred behind a host RTS).
// Ports: clk/n_rst system clock and async active-low reset; clk_in/data_in sensed line levels;
//        n_clk_out/n_data_out open-drain pull-downs (1 = pull low); tx_data/tx_valid/tx_ready byte-to-host handshake;
//        rx_data last host byte, rx_valid/rx_err one-cycle completion pulses; busy while a frame is active.
module ps2_device #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clk_in,
  input  logic       data_in,
  output logic       n_clk_out,
  output logic       n_data_out,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_err,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, TX, RX, ACK} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [9:0] HI_NEED  = 10'(2 * CLK_DIV);
  // Our own clock release needs two cycles to reach clk_s; earlier cycles of a high half still see our pull-down.
  localparam logic [7:0] SYNC_LAT = 8'd2;

  state_t      state;
  logic        clk_meta, clk_s, dat_meta, dat_s;
  logic        rts_seen;
  logic [7:0]  div_cnt;
  logic        phase_lo;   // 0: high half-period (clock released), 1: low half-period
  logic [3:0]  bit_cnt;
  logic [9:0]  shreg;      // TX: remaining frame bits; RX: bits shifted in from the top
  logic [7:0]  tx_byte;
  logic        pend;       // a byte is held for transmission
  logic        retry;      // held byte was inhibited; wait for a quiet clock before resending
  logic [9:0]  hi_cnt;     // consecutive cycles of high clk_s, saturating at HI_NEED

  logic        accept, rts_now, hi_ok, half_end;
  logic [7:0]  tx_src;
  logic [10:0] tx_frame;

  assign accept   = tx_valid & tx_ready;
  assign rts_now  = rts_seen & clk_s & ~dat_s;
  assign hi_ok    = (hi_cnt >= HI_NEED);
  assign half_end = (div_cnt == DIV_LAST);
  assign tx_src   = pend ? tx_byte : tx_data;
  assign tx_frame = {1'b1, ~^tx_src, tx_src, 1'b0};   // stop, odd parity, data LSB first, start
  assign busy     = (state != IDLE);
  assign tx_ready = ~pend;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state      <= IDLE;
      clk_meta   <= 1'b0;
      clk_s      <= 1'b0;
      dat_meta   <= 1'b0;
      dat_s      <= 1'b0;
      rts_seen   <= 1'b0;
      div_cnt    <= 8'd0;
      phase_lo   <= 1'b0;
      bit_cnt    <= 4'd0;
      shreg      <= 10'd0;
      tx_byte    <= 8'd0;
      pend       <= 1'b0;
      retry      <= 1'b0;
      hi_cnt     <= 10'd0;
      n_clk_out  <= 1'b0;
      n_data_out <= 1'b0;
      rx_data    <= 8'd0;
      rx_valid   <= 1'b0;
      rx_err     <= 1'b0;
    end else begin
      clk_meta <= clk_in;
      clk_s    <= clk_meta;
      dat_meta <= data_in;
      dat_s    <= dat_meta;
      rts_seen <= clk_s & ~dat_s;
      hi_cnt   <= clk_s ? (hi_ok ? hi_cnt : hi_cnt + 10'd1) : 10'd0;
      rx_valid <= 1'b0;
      rx_err   <= 1'b0;

      if (accept) begin
        pend    <= 1'b1;
        tx_byte <= tx_data;
      end

      case (state)
        IDLE: begin
          div_cnt  <= 8'd0;
          phase_lo <= 1'b0;
          bit_cnt  <= 4'd0;
          if (rts_now) begin
            // Host RTS beats any byte waiting to go out; that byte stays pending.
            state      <= RX;
            n_clk_out  <= 1'b0;
            n_data_out <= 1'b0;
          end else if (accept || (pend && (!retry || hi_ok))) begin
            state      <= TX;
            retry      <= 1'b0;
            n_clk_out  <= 1'b0;
            n_data_out <= ~tx_frame[0];
            shreg      <= tx_frame[10:1];
          end
        end

        TX: begin
          if (!phase_lo && bit_cnt != 4'd10 && div_cnt >= SYNC_LAT && !clk_s) begin
            // Host inhibit: drop the frame, keep the byte, resend from the start bit later.
            state      <= IDLE;
            retry      <= 1'b1;
            n_clk_out  <= 1'b0;
            n_data_out <= 1'b0;
          end else if (half_end) begin
            div_cnt <= 8'd0;
            if (!phase_lo) begin
              phase_lo  <= 1'b1;
              n_clk_out <= 1'b1;
            end else if (bit_cnt == 4'd10) begin
              state      <= IDLE;
              pend       <= 1'b0;
              n_clk_out  <= 1'b0;
              n_data_out <= 1'b0;
            end else begin
              phase_lo   <= 1'b0;
              n_clk_out  <= 1'b0;
              bit_cnt    <= bit_cnt + 4'd1;
              n_data_out <= ~shreg[0];
              shreg      <= {1'b0, shreg[9:1]};
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        RX: begin
          if (half_end) begin
            div_cnt <= 8'd0;
            if (!phase_lo) begin
              phase_lo  <= 1'b1;
              n_clk_out <= 1'b1;
              shreg     <= {dat_s, shreg[9:1]};   // sample at the last cycle of the high half
            end else if (bit_cnt == 4'd9) begin
              phase_lo <= 1'b0;
              if (shreg[9]) begin
                state      <= ACK;
                n_clk_out  <= 1'b0;
                n_data_out <= 1'b1;
              end else begin
                // Bad stop bit: no ACK pulse, report the error immediately.
                state     <= IDLE;
                n_clk_out <= 1'b0;
                rx_data   <= shreg[7:0];
                rx_err    <= 1'b1;
              end
            end else begin
              phase_lo  <= 1'b0;
              n_clk_out <= 1'b0;
              bit_cnt   <= bit_cnt + 4'd1;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        ACK: begin
          if (half_end) begin
            div_cnt <= 8'd0;
            if (!phase_lo) begin
              phase_lo  <= 1'b1;
              n_clk_out <= 1'b1;
            end else begin
              state      <= IDLE;
              phase_lo   <= 1'b0;
              n_clk_out  <= 1'b0;
              n_data_out <= 1'b0;
              rx_data    <= shreg[7:0];
              if (^shreg[8:0]) rx_valid <= 1'b1;
              else             rx_err   <= 1'b1;
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
